// File: rtl/bus_arbiter85_if.sv
// bus_arbiter85_if: groups the HOLD/HLDA handshake and grant signals shared
// between the 8085 bus arbiter and the system around it.
//   req   requester lines, level, one per requester (NREQ bits)
//   hlda  hold acknowledge from the core
//   hold  hold request to the core
//   gnt   one-hot bus grant (NREQ bits)
//   gid   index of the granted requester (IDXSIZE bits)
//   busy  arbiter is in any state other than IDLE
// Modports: master = arbiter side, slave = requesters/core side.
interface bus_arbiter85_if #(
    parameter int unsigned NREQ    = 4,
    parameter int unsigned IDXSIZE = 2
);
    logic [NREQ-1:0]    req;
    logic               hlda;
    logic               hold;
    logic [NREQ-1:0]    gnt;
    logic [IDXSIZE-1:0] gid;
    logic               busy;

    modport master (
        input  req,
        input  hlda,
        output hold,
        output gnt,
        output gid,
        output busy
    );

    modport slave (
        output req,
        output hlda,
        input  hold,
        input  gnt,
        input  gid,
        input  busy
    );
endinterface

// File: rtl/bus_arbiter85.sv
// bus_arbiter85: shares the 8085 external bus between NREQ requesters using
// the core's HOLD/HLDA handshake. Raises hold, waits for hlda, grants the bus
// one-hot to a round-robin winner, then hands the bus back to the core with
// at least one IDLE cycle between grants. All outputs are registered.
// Ports:
//   clk   system clock, all state changes on posedge
//   rst_  asynchronous active-low reset
//   bus   bus_arbiter85_if.master (req, hlda in; hold, gnt, gid, busy out)
// Optional feature: define BURST_LIMIT_EN to cap every grant at exactly
// MAXBURST clk cycles; without it a grant lasts until req or hlda falls.
module bus_arbiter85 #(
    parameter int unsigned NREQ     = 4,
    parameter int unsigned IDXSIZE  = 2,
    parameter int unsigned MAXBURST = 16
) (
    input  logic              clk,
    input  logic              rst_,
    bus_arbiter85_if.master   bus
);
    typedef enum logic [1:0] {IDLE, HREQ, GRANT, RELS} state_t;

    state_t             state, state_nx;
    logic [IDXSIZE-1:0] winner, winner_nx;
    logic [IDXSIZE-1:0] rr_ptr, rr_ptr_nx;
    logic [IDXSIZE-1:0] gid_q, gid_nx;
    logic               granted, granted_nx;
    logic               hold_q, hold_nx;
    logic               busy_q, busy_nx;
    logic [NREQ-1:0]    gnt_q, gnt_nx;
    logic [IDXSIZE-1:0] pick;
    logic               pick_valid;

`ifdef BURST_LIMIT_EN
    localparam int unsigned CNTW = (MAXBURST > 1) ? $clog2(MAXBURST) : 1;
    logic [CNTW-1:0] cnt, cnt_nx;
`endif

    // First asserted request at or after rr_ptr, wrapping NREQ-1 -> 0.
    always_comb begin
        int unsigned idx;
        pick       = '0;
        pick_valid = 1'b0;
        idx        = 0;
        for (int unsigned i = 0; i < NREQ; i++) begin
            idx = (32'(rr_ptr) + i) % NREQ;
            if (!pick_valid && bus.req[idx]) begin
                pick       = IDXSIZE'(idx);
                pick_valid = 1'b1;
            end
        end
    end

    always_comb begin
        state_nx   = state;
        winner_nx  = winner;
        rr_ptr_nx  = rr_ptr;
        granted_nx = granted;
        gid_nx     = gid_q;
        gnt_nx     = '0;
`ifdef BURST_LIMIT_EN
        cnt_nx     = cnt;
`endif
        case (state)
            IDLE: begin
                // A spurious hlda here is ignored: no grant without hold.
                if (pick_valid) begin
                    state_nx   = HREQ;
                    winner_nx  = pick;
                    granted_nx = 1'b0;
                end
            end
            HREQ: begin
                // Request withdrawal wins over a simultaneous hlda rise.
                if (!bus.req[winner]) begin
                    state_nx = RELS;
                end else if (bus.hlda) begin
                    state_nx        = GRANT;
                    granted_nx      = 1'b1;
                    gid_nx          = winner;
                    gnt_nx[winner]  = 1'b1;
`ifdef BURST_LIMIT_EN
                    cnt_nx          = '0;
`endif
                end
            end
            GRANT: begin
                if (!bus.req[winner] || !bus.hlda) begin
                    state_nx = RELS;
                end
`ifdef BURST_LIMIT_EN
                else if (cnt == CNTW'(MAXBURST - 1)) begin
                    state_nx = RELS;
                end
`endif
                else begin
                    gnt_nx[winner] = 1'b1;
`ifdef BURST_LIMIT_EN
                    cnt_nx         = cnt + 1'b1;
`endif
                end
            end
            RELS: begin
                // Pointer only moves past a requester that actually got the bus.
                if (!bus.hlda) begin
                    state_nx = IDLE;
                    if (granted) begin
                        rr_ptr_nx = IDXSIZE'((32'(winner) + 1) % NREQ);
                    end
                end
            end
            default: state_nx = IDLE;
        endcase
        hold_nx = (state_nx == HREQ) || (state_nx == GRANT);
        busy_nx = (state_nx != IDLE);
    end

    always_ff @(posedge clk or negedge rst_) begin
        if (!rst_) begin
            state   <= IDLE;
            winner  <= '0;
            rr_ptr  <= '0;
            granted <= 1'b0;
            gid_q   <= '0;
            gnt_q   <= '0;
            hold_q  <= 1'b0;
            busy_q  <= 1'b0;
`ifdef BURST_LIMIT_EN
            cnt     <= '0;
`endif
        end else begin
            state   <= state_nx;
            winner  <= winner_nx;
            rr_ptr  <= rr_ptr_nx;
            granted <= granted_nx;
            gid_q   <= gid_nx;
            gnt_q   <= gnt_nx;
            hold_q  <= hold_nx;
            busy_q  <= busy_nx;
`ifdef BURST_LIMIT_EN
            cnt     <= cnt_nx;
`endif
        end
    end

    assign bus.hold = hold_q;
    assign bus.gnt  = gnt_q;
    assign bus.gid  = gid_q;
    assign bus.busy = busy_q;
endmodule

// File: tb/tb_bus_arbiter85.sv
// tb_bus_arbiter85: directed scenarios plus randomized req/hlda traffic,
// every cycle checked against a behavioural model of the arbiter's rules.
module tb_bus_arbiter85;
    localparam int NREQ     = 4;
    localparam int IDXSIZE  = 2;
    localparam int MAXBURST = 16;

    logic clk = 1'b0;
    logic rst_;
    always #5 clk = ~clk;

    bus_arbiter85_if #(.NREQ(NREQ), .IDXSIZE(IDXSIZE)) bus ();

    bus_arbiter85 #(.NREQ(NREQ), .IDXSIZE(IDXSIZE), .MAXBURST(MAXBURST)) dut (
        .clk  (clk),
        .rst_ (rst_),
        .bus  (bus)
    );

    int n_cmp = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Model: phase 0=bus with core, 1=hold requested, 2=bus granted, 3=releasing.
    int m_phase, m_owner, m_ptr, m_len;
    bit m_issued;

    function automatic void model_reset();
        m_phase = 0; m_owner = 0; m_ptr = 0; m_len = 0; m_issued = 0;
    endfunction

    function automatic void model_step(input logic [NREQ-1:0] r, input logic h);
        case (m_phase)
            0: if (r != 0) begin
                for (int i = 0; i < NREQ; i++) begin
                    if (r[(m_ptr + i) % NREQ]) begin
                        m_owner = (m_ptr + i) % NREQ;
                        break;
                    end
                end
                m_issued = 0;
                m_phase  = 1;
            end
            1: if (!r[m_owner]) m_phase = 3;
               else if (h) begin m_phase = 2; m_len = 1; m_issued = 1; end
            2: if (!r[m_owner] || !h) m_phase = 3;
`ifdef BURST_LIMIT_EN
               else if (m_len == MAXBURST) m_phase = 3;
`endif
               else m_len++;
            default: if (!h) begin
                m_phase = 0;
                if (m_issued) m_ptr = (m_owner + 1) % NREQ;
            end
        endcase
    endfunction

    task automatic check_outputs();
        chk("hold", bus.hold, (m_phase == 1 || m_phase == 2));
        chk("busy", bus.busy, (m_phase != 0));
        chk("gnt", bus.gnt, (m_phase == 2) ? (32'd1 << m_owner) : 32'd0);
        if (m_phase == 2) chk("gid", bus.gid, m_owner);
    endtask

    // One clock: drive at negedge, model on posedge, check at next negedge.
    task automatic cycle(input logic [NREQ-1:0] r, input logic h);
        bus.req  = r;
        bus.hlda = h;
        @(posedge clk);
        model_step(r, h);
        @(negedge clk);
        check_outputs();
    endtask

    task automatic do_reset();
        rst_ = 1'b0; bus.req = '0; bus.hlda = 1'b0;
        model_reset();
        @(negedge clk);
        @(negedge clk);
        check_outputs();
        chk("rst_gid", bus.gid, 0);
        rst_ = 1'b1;
    endtask

    logic [NREQ-1:0] rq, prev_gnt;
    logic            hh;
    int              k, gl, order[5];
    bit              saw_idle, done;

    initial begin
        rst_ = 1'b1; bus.req = '0; bus.hlda = 1'b0;
        model_reset();
        @(negedge clk);
        do_reset();

        // Asynchronous reset in the middle of a grant to requester 1.
        done = 0;
        for (int c = 0; c < 20 && !done; c++) begin
            cycle(4'b0010, bus.hold);
            if (bus.gnt != 0) done = 1;
        end
        chk("t1_reach_grant", done, 1);
        chk("t1_gnt_before", bus.gnt, 4'b0010);
        #2 rst_ = 1'b0;
        #1;
        chk("t1_hold", bus.hold, 0);
        chk("t1_gnt", bus.gnt, 0);
        chk("t1_busy", bus.busy, 0);
        chk("t1_gid", bus.gid, 0);
        model_reset();
        bus.req = '0;
        @(negedge clk);
        rst_ = 1'b1;

        // Single request, hlda two cycles after hold.
        cycle(4'b0100, 1'b0);
        chk("t2_hold", bus.hold, 1);
        cycle(4'b0100, 1'b0);
        cycle(4'b0100, 1'b1);
        chk("t2_gnt", bus.gnt, 4'b0100);
        chk("t2_gid", bus.gid, 2);
        cycle(4'b0100, 1'b1);
        cycle(4'b0000, 1'b1);
        chk("t2_rel_gnt", bus.gnt, 0);
        chk("t2_rel_hold", bus.hold, 0);
        cycle(4'b0000, 1'b0);
        chk("t2_idle", bus.busy, 0);

        // Round robin: everyone requests, the grantee drops its line once served.
        do_reset();
        k = 0; prev_gnt = '0; saw_idle = 0;
        for (int c = 0; c < 200 && k < 5; c++) begin
            cycle(4'b1111 & ~bus.gnt, bus.hold);
            if (!bus.busy) saw_idle = 1;
            if (bus.gnt != 0 && prev_gnt == 0) begin
                if (k > 0) chk("t3_idle_between", saw_idle, 1);
                order[k] = int'(bus.gid);
                k++;
                saw_idle = 0;
            end
            prev_gnt = bus.gnt;
        end
        chk("t3_grants_seen", k, 5);
        for (int i = 0; i < k; i++) chk("t3_order", order[i], i % 4);

        // Abandon in HREQ: no grant, pointer stays at 0.
        do_reset();
        cycle(4'b0001, 1'b0);
        chk("t4_hold", bus.hold, 1);
        cycle(4'b0000, 1'b0);
        chk("t4_hold_fall", bus.hold, 0);
        chk("t4_gnt", bus.gnt, 0);
        cycle(4'b0000, 1'b0);
        done = 0;
        for (int c = 0; c < 20 && !done; c++) begin
            cycle(4'b0011, bus.hold);
            if (bus.gnt != 0) done = 1;
        end
        chk("t4_regrant", done, 1);
        chk("t4_ptr_kept", bus.gid, 0);

        // Core withdraws hlda during a grant.
        do_reset();
        done = 0;
        for (int c = 0; c < 20 && !done; c++) begin
            cycle(4'b0010, bus.hold);
            if (bus.gnt != 0) done = 1;
        end
        chk("t5_reach_grant", done, 1);
        cycle(4'b0010, 1'b0);
        chk("t5_gnt", bus.gnt, 0);
        chk("t5_hold", bus.hold, 0);
        chk("t5_rels_busy", bus.busy, 1);
        cycle(4'b0000, 1'b0);
        chk("t5_idle", bus.busy, 0);

`ifdef BURST_LIMIT_EN
        // Held request is cut off after exactly MAXBURST cycles, then re-granted.
        do_reset();
        gl = 0; k = 0; prev_gnt = '0;
        for (int c = 0; c < 100 && k < 2; c++) begin
            cycle(4'b0001, bus.hold);
            if (bus.gnt != 0 && prev_gnt == 0) k++;
            if (k == 1 && bus.gnt != 0) gl++;
            prev_gnt = bus.gnt;
        end
        chk("t6_burst_len", gl, MAXBURST);
        chk("t6_regrant", k, 2);
`endif

        // Random traffic; hlda loosely follows hold with random lag and glitches.
        do_reset();
        rq = '0; hh = 1'b0;
        for (int c = 0; c < 3000; c++) begin
            for (int b = 0; b < NREQ; b++)
                if ($urandom_range(0, 5) == 0) rq[b] = ~rq[b];
            if ((bus.gnt & rq) != 0 && $urandom_range(0, 3) == 0) rq = rq & ~bus.gnt;
            k = $urandom_range(0, 15);
            if (k < 9) hh = bus.hold;
            else if (k == 15) hh = ~hh;
            cycle(rq, hh);
            chk("rnd_gnt_needs_hold", (bus.gnt != 0) && !bus.hold, 0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
